// File: rtl/writeback_arbiter_pkg.sv
// Shared types and helpers for the register-file writeback path.
// Holds the queued-result record and the WAW lookup used by the arbiter.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_XLEN    = 32;
    // Widest holding queue the WAW lookup can scan; narrower queues are zero-padded.
    localparam int AQ_MAX     = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]    data;
    } wb_entry_t;

    function automatic logic rd_match(
        input logic [AQ_MAX-1:0]                 q_valid,
        input logic [AQ_MAX-1:0][REG_ADDR_W-1:0] q_rd,
        input logic [REG_ADDR_W-1:0]             rd
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < AQ_MAX; i++) begin
            if (q_valid[i] && (q_rd[i] == rd)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of ALU/load result handshakes, issue tracking and register-file write outputs.
// master = producers and register file side, slave = the writeback arbiter.
interface writeback_arbiter_if
    import wb_pkg::*;
#(
    parameter int XLEN = WB_XLEN
);

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;

    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_ready;

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;

    logic                  rf_write;
    logic [REG_ADDR_W-1:0] rf_writeReg;
    logic [XLEN-1:0]       rf_writeData;
    logic [NUM_REGS-1:0]   pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output issue_valid, issue_rd,
        input  rf_write, rf_writeReg, rf_writeData, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  issue_valid, issue_rd,
        output rf_write, rf_writeReg, rf_writeData, pending
    );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// In-order holding queue for ALU results that lose the write port to a load.
// Head is read combinationally so it can be popped in the cycle it is selected.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_i,
    input  wb_entry_t                        push_entry_i,
    input  logic                             pop_i,
    output logic                             full_o,
    output logic                             empty_o,
    output wb_entry_t                        head_o,
    output logic [DEPTH-1:0]                 valid_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Slot gi is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            logic [PTR_W-1:0] offset;
            assign offset      = PTR_W'(gi) - rd_ptr_q;
            assign valid_o[gi] = ({1'b0, offset} < count_q);
            assign rd_o[gi]    = mem_q[gi].rd;
        end
    endgenerate

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writer merging ALU and load results, with a
// pending-register scoreboard for the read side.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN     = WB_XLEN,
    parameter int AQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    writeback_arbiter_if.slave wb
);

    logic                                fifo_full;
    logic                                fifo_empty;
    wb_entry_t                           fifo_head;
    logic [AQ_DEPTH-1:0]                 q_valid;
    logic [AQ_DEPTH-1:0][REG_ADDR_W-1:0] q_rd;
    logic [AQ_MAX-1:0]                   q_valid_pad;
    logic [AQ_MAX-1:0][REG_ADDR_W-1:0]   q_rd_pad;

    logic      waw_hit;
    logic      alu_acc;
    logic      ld_acc;
    logic      ld_write;
    logic      push;
    logic      pop;
    wb_entry_t alu_entry;
    wb_entry_t ld_entry;

    logic                  rf_write_q, rf_write_d;
    logic [REG_ADDR_W-1:0] rf_reg_q, rf_reg_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    wb_fifo #(
        .DEPTH (AQ_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (alu_entry),
        .pop_i        (pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head),
        .valid_o      (q_valid),
        .rd_o         (q_rd)
    );

    generate
        for (genvar gi = 0; gi < AQ_MAX; gi++) begin : g_pad
            if (gi < AQ_DEPTH) begin : g_live
                assign q_valid_pad[gi] = q_valid[gi];
                assign q_rd_pad[gi]    = q_rd[gi];
            end else begin : g_zero
                assign q_valid_pad[gi] = 1'b0;
                assign q_rd_pad[gi]    = '0;
            end
        end
    endgenerate

    // A load may not overtake an older queued ALU result to the same register.
    assign waw_hit = (wb.ld_rd != '0) && rd_match(q_valid_pad, q_rd_pad, wb.ld_rd);

    assign wb.alu_ready = !fifo_full;
    assign wb.ld_ready  = !fifo_full && !waw_hit;

    assign alu_acc  = wb.alu_valid && !fifo_full && (wb.alu_rd != '0);
    assign ld_acc   = wb.ld_valid && wb.ld_ready;
    assign ld_write = ld_acc && (wb.ld_rd != '0);

    assign alu_entry.rd   = wb.alu_rd;
    assign alu_entry.data = wb.alu_data;
    assign ld_entry.rd    = wb.ld_rd;
    assign ld_entry.data  = wb.ld_data;

    // Priority: load, then queue head, then the incoming ALU result straight through.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        rf_write_d = 1'b0;
        rf_reg_d   = rf_reg_q;
        rf_data_d  = rf_data_q;
        if (ld_write) begin
            rf_write_d = 1'b1;
            rf_reg_d   = ld_entry.rd;
            rf_data_d  = ld_entry.data;
            push       = alu_acc;
        end else if (!fifo_empty) begin
            rf_write_d = 1'b1;
            rf_reg_d   = fifo_head.rd;
            rf_data_d  = fifo_head.data;
            pop        = 1'b1;
            push       = alu_acc;
        end else if (alu_acc) begin
            rf_write_d = 1'b1;
            rf_reg_d   = alu_entry.rd;
            rf_data_d  = alu_entry.data;
        end
    end

    // A new issue to the register outranks the commit of the older write.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                logic set_b;
                logic clr_b;
                assign set_b = wb.issue_valid && (wb.issue_rd == REG_ADDR_W'(gi));
                assign clr_b = rf_write_q && (rf_reg_q == REG_ADDR_W'(gi));
                assign pending_d[gi] = set_b || (pending_q[gi] && !clr_b);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_q <= 1'b0;
            rf_reg_q   <= '0;
            rf_data_q  <= '0;
            pending_q  <= '0;
        end else begin
            rf_write_q <= rf_write_d;
            rf_reg_q   <= rf_reg_d;
            rf_data_q  <= rf_data_d;
            pending_q  <= pending_d;
        end
    end

    assign wb.rf_write     = rf_write_q;
    assign wb.rf_writeReg  = rf_reg_q;
    assign wb.rf_writeData = rf_data_q;
    assign wb.pending      = pending_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed scenario bench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   passed;

    writeback_arbiter_if #(.XLEN(32)) wb_if ();

    writeback_arbiter #(
        .XLEN     (32),
        .AQ_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_if.alu_valid   = 1'b0;
        wb_if.alu_rd      = '0;
        wb_if.alu_data    = '0;
        wb_if.ld_valid    = 1'b0;
        wb_if.ld_rd       = '0;
        wb_if.ld_data     = '0;
        wb_if.issue_valid = 1'b0;
        wb_if.issue_rd    = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL reset_write: got %b want 0", wb_if.rf_write); else passed++;
        checks++; if (wb_if.rf_writeReg !== 5'd0) $display("FAIL reset_reg: got %0d want 0", wb_if.rf_writeReg); else passed++;
        checks++; if (wb_if.rf_writeData !== 32'h0) $display("FAIL reset_data: got %h want 0", wb_if.rf_writeData); else passed++;
        checks++; if (wb_if.pending !== 32'h0) $display("FAIL reset_pending: got %h want 0", wb_if.pending); else passed++;
        checks++; if (wb_if.alu_ready !== 1'b1) $display("FAIL reset_alu_ready: got %b want 1", wb_if.alu_ready); else passed++;
        checks++; if (wb_if.ld_ready !== 1'b1) $display("FAIL reset_ld_ready: got %b want 1", wb_if.ld_ready); else passed++;
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_alu();
        wb_if.issue_valid = 1'b1;
        wb_if.issue_rd    = 5'd5;
        tick();
        wb_if.issue_valid = 1'b0;
        checks++; if (wb_if.pending !== 32'h0000_0020) $display("FAIL single_pending_set: got %h want 00000020", wb_if.pending); else passed++;
        wb_if.alu_valid = 1'b1;
        wb_if.alu_rd    = 5'd5;
        wb_if.alu_data  = 32'hDEAD_BEEF;
        #1;
        checks++; if (wb_if.alu_ready !== 1'b1) $display("FAIL single_alu_ready: got %b want 1", wb_if.alu_ready); else passed++;
        tick();
        wb_if.alu_valid = 1'b0;
        checks++; if (wb_if.rf_write !== 1'b1) $display("FAIL single_write: got %b want 1", wb_if.rf_write); else passed++;
        checks++; if (wb_if.rf_writeReg !== 5'd5) $display("FAIL single_reg: got %0d want 5", wb_if.rf_writeReg); else passed++;
        checks++; if (wb_if.rf_writeData !== 32'hDEAD_BEEF) $display("FAIL single_data: got %h want deadbeef", wb_if.rf_writeData); else passed++;
        checks++; if (wb_if.pending !== 32'h0000_0020) $display("FAIL single_pending_held: got %h want 00000020", wb_if.pending); else passed++;
        tick();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL single_idle: got %b want 0", wb_if.rf_write); else passed++;
        checks++; if (wb_if.pending !== 32'h0) $display("FAIL single_pending_clr: got %h want 0", wb_if.pending); else passed++;
        checks++; if (wb_if.rf_writeData !== 32'hDEAD_BEEF) $display("FAIL single_data_hold: got %h want deadbeef", wb_if.rf_writeData); else passed++;
        $display("test_single_alu done");
    endtask

    task automatic test_collision();
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd3; wb_if.alu_data = 32'h11;
        wb_if.ld_valid  = 1'b1; wb_if.ld_rd  = 5'd4; wb_if.ld_data  = 32'h22;
        #1;
        checks++; if (wb_if.ld_ready !== 1'b1) $display("FAIL coll_ld_ready: got %b want 1", wb_if.ld_ready); else passed++;
        tick();
        clear_inputs();
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd4, 32'h22})
            $display("FAIL coll_first: got w=%b r=%0d d=%h want w=1 r=4 d=22", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        checks++; if (wb_if.alu_ready !== 1'b1) $display("FAIL coll_alu_ready: got %b want 1", wb_if.alu_ready); else passed++;
        tick();
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd3, 32'h11})
            $display("FAIL coll_second: got w=%b r=%0d d=%h want w=1 r=3 d=11", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        tick();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL coll_idle: got %b want 0", wb_if.rf_write); else passed++;
        $display("test_collision done");
    endtask

    task automatic test_waw();
        wb_if.ld_valid  = 1'b1; wb_if.ld_rd  = 5'd9; wb_if.ld_data  = 32'h99;
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd7; wb_if.alu_data = 32'hA;
        tick();
        wb_if.alu_valid = 1'b0;
        wb_if.ld_rd     = 5'd7;
        wb_if.ld_data   = 32'hB;
        #1;
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg} !== {1'b1, 5'd9}) $display("FAIL waw_ld9: got w=%b r=%0d want w=1 r=9", wb_if.rf_write, wb_if.rf_writeReg); else passed++;
        checks++; if (wb_if.ld_ready !== 1'b0) $display("FAIL waw_block: got %b want 0", wb_if.ld_ready); else passed++;
        tick();
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd7, 32'hA})
            $display("FAIL waw_old: got w=%b r=%0d d=%h want w=1 r=7 d=a", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        checks++; if (wb_if.ld_ready !== 1'b1) $display("FAIL waw_release: got %b want 1", wb_if.ld_ready); else passed++;
        tick();
        wb_if.ld_valid = 1'b0;
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd7, 32'hB})
            $display("FAIL waw_new: got w=%b r=%0d d=%h want w=1 r=7 d=b", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        tick();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL waw_idle: got %b want 0", wb_if.rf_write); else passed++;
        clear_inputs();
        $display("test_waw done");
    endtask

    task automatic test_x0();
        wb_if.alu_valid   = 1'b1; wb_if.alu_rd   = 5'd0; wb_if.alu_data = 32'h55;
        wb_if.ld_valid    = 1'b1; wb_if.ld_rd    = 5'd0; wb_if.ld_data  = 32'h66;
        wb_if.issue_valid = 1'b1; wb_if.issue_rd = 5'd0;
        #1;
        checks++; if ({wb_if.alu_ready, wb_if.ld_ready} !== 2'b11) $display("FAIL x0_ready: got %b want 11", {wb_if.alu_ready, wb_if.ld_ready}); else passed++;
        tick();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL x0_write1: got %b want 0", wb_if.rf_write); else passed++;
        checks++; if (wb_if.pending !== 32'h0) $display("FAIL x0_pending: got %h want 0", wb_if.pending); else passed++;
        tick();
        clear_inputs();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL x0_write2: got %b want 0", wb_if.rf_write); else passed++;
        tick();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL x0_write3: got %b want 0", wb_if.rf_write); else passed++;
        checks++; if (wb_if.alu_ready !== 1'b1) $display("FAIL x0_empty: got %b want 1", wb_if.alu_ready); else passed++;
        $display("test_x0 done");
    endtask

    task automatic test_starvation();
        wb_if.ld_valid  = 1'b1; wb_if.ld_rd  = 5'd10; wb_if.ld_data  = 32'h100;
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd11; wb_if.alu_data = 32'h111;
        tick();
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg} !== {1'b1, 5'd10}) $display("FAIL starve_ld10: got w=%b r=%0d want w=1 r=10", wb_if.rf_write, wb_if.rf_writeReg); else passed++;
        wb_if.ld_rd  = 5'd12; wb_if.ld_data  = 32'h200;
        wb_if.alu_rd = 5'd13; wb_if.alu_data = 32'h222;
        #1;
        checks++; if ({wb_if.alu_ready, wb_if.ld_ready} !== 2'b11) $display("FAIL starve_half: got %b want 11", {wb_if.alu_ready, wb_if.ld_ready}); else passed++;
        tick();
        wb_if.alu_valid = 1'b0;
        wb_if.ld_rd     = 5'd14; wb_if.ld_data = 32'h300;
        #1;
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd12, 32'h200})
            $display("FAIL starve_ld12: got w=%b r=%0d d=%h want w=1 r=12 d=200", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        checks++; if ({wb_if.alu_ready, wb_if.ld_ready} !== 2'b00) $display("FAIL starve_full: got %b want 00", {wb_if.alu_ready, wb_if.ld_ready}); else passed++;
        tick();
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd11, 32'h111})
            $display("FAIL starve_head: got w=%b r=%0d d=%h want w=1 r=11 d=111", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        checks++; if ({wb_if.alu_ready, wb_if.ld_ready} !== 2'b11) $display("FAIL starve_reassert: got %b want 11", {wb_if.alu_ready, wb_if.ld_ready}); else passed++;
        tick();
        wb_if.ld_valid = 1'b0;
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd14, 32'h300})
            $display("FAIL starve_ld14: got w=%b r=%0d d=%h want w=1 r=14 d=300", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        tick();
        checks++; if ({wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData} !== {1'b1, 5'd13, 32'h222})
            $display("FAIL starve_tail: got w=%b r=%0d d=%h want w=1 r=13 d=222", wb_if.rf_write, wb_if.rf_writeReg, wb_if.rf_writeData); else passed++;
        tick();
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL starve_idle: got %b want 0", wb_if.rf_write); else passed++;
        clear_inputs();
        $display("test_starvation done");
    endtask

    task automatic test_reset_mid();
        wb_if.issue_valid = 1'b1; wb_if.issue_rd = 5'd21;
        tick();
        wb_if.issue_rd = 5'd23;
        tick();
        wb_if.issue_valid = 1'b0;
        checks++; if (wb_if.pending !== 32'h00A0_0000) $display("FAIL rmid_pending: got %h want 00a00000", wb_if.pending); else passed++;
        wb_if.ld_valid  = 1'b1; wb_if.ld_rd  = 5'd20; wb_if.ld_data  = 32'h1;
        wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd21; wb_if.alu_data = 32'h2;
        tick();
        wb_if.ld_rd  = 5'd22; wb_if.ld_data  = 32'h3;
        wb_if.alu_rd = 5'd23; wb_if.alu_data = 32'h4;
        tick();
        clear_inputs();
        #1;
        checks++; if ({wb_if.rf_write, wb_if.alu_ready} !== 2'b10) $display("FAIL rmid_full: got %b want 10", {wb_if.rf_write, wb_if.alu_ready}); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL rmid_write: got %b want 0", wb_if.rf_write); else passed++;
        checks++; if (wb_if.pending !== 32'h0) $display("FAIL rmid_pend_clr: got %h want 0", wb_if.pending); else passed++;
        checks++; if (wb_if.alu_ready !== 1'b1) $display("FAIL rmid_queue: got %b want 1", wb_if.alu_ready); else passed++;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (wb_if.rf_write !== 1'b0) $display("FAIL rmid_stale%0d: got %b want 0", i, wb_if.rf_write); else passed++;
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset  = 1'b1;
        clear_inputs();
        test_reset();
        test_single_alu();
        test_collision();
        test_waw();
        test_x0();
        test_starvation();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
